// File: rtl/bus_arbiter_pkg.sv
// Shared widths, bus signal levels and arbiter state encoding for the system bus arbiter.
package bus_arbiter_pkg;

    localparam int BUS_ADDR_WIDTH = 16;
    localparam int BUS_DATA_WIDTH = 16;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_OWNED   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after index 'last', wrapping to 0.
module bus_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    always_comb begin
        int cand;
        cand   = 0;
        valid  = 1'b0;
        winner = '0;
        for (int i = 1; i <= N; i++) begin
            cand = int'(last) + i;
            if (cand >= N) cand = cand - N;
            if (!valid && req[IDX_W'(cand)]) begin
                valid  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration for the shared system bus, with owner mux, ready routing
// and abort of strobes a slave leaves unanswered for TIMEOUT cycles.
//
//   state       | meaning
//   ARB_IDLE    | bus free; pick next requester after last owner
//   ARB_OWNED   | owner's grant low; owner's signals muxed onto the bus
//   ARB_RELEASE | one dead cycle; last-granted pointer takes the old owner
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 16,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_MASTERS-1:0]               m_req_,
    output logic [NUM_MASTERS-1:0]               m_gnt_,
    input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]               m_as_,
    input  logic [NUM_MASTERS-1:0]               m_rw,
    input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]               m_rdy_,
    output logic [NUM_MASTERS-1:0]               m_err_,
    output logic [BUS_ADDR_WIDTH-1:0]            bus_addr,
    output logic                                 bus_as_,
    output logic                                 bus_rw,
    output logic [BUS_DATA_WIDTH-1:0]            bus_wr_data,
    input  logic                                 bus_rdy_
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [NUM_MASTERS-1:0] gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;
    logic             abort_q, abort_d;
    logic             owned, as_eff_, busy, fire;

    logic [BUS_ADDR_WIDTH-1:0] addr_arr [NUM_MASTERS];
    logic [BUS_DATA_WIDTH-1:0] data_arr [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign addr_arr[g] = m_addr[g*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
        assign data_arr[g] = m_wr_data[g*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end

    bus_arbiter_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (~m_req_),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // A forced abort keeps the strobe masked until the owner lifts its own m_as_.
    assign owned   = (state_q == ARB_OWNED);
    assign as_eff_ = !owned || m_as_[owner_q] || abort_q;
    assign busy    = !as_eff_ && bus_rdy_;
    assign fire    = busy && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                if (m_req_[owner_q] && !busy) state_d = ARB_RELEASE;
            end
            ARB_RELEASE: begin
                last_d  = owner_q;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase

        gnt_d = {NUM_MASTERS{DISABLE_}};
        if (state_d == ARB_OWNED) gnt_d[owner_d] = ENABLE_;

        if (fire)      cnt_d = '0;
        else if (busy) cnt_d = cnt_q + 1'b1;
        else           cnt_d = '0;

        if (!owned)              abort_d = 1'b0;
        else if (fire)           abort_d = 1'b1;
        else if (m_as_[owner_q]) abort_d = 1'b0;
        else                     abort_d = abort_q;
    end

    always_comb begin
        bus_addr    = '0;
        bus_wr_data = '0;
        bus_rw      = READ;
        bus_as_     = DISABLE_;
        m_rdy_      = {NUM_MASTERS{DISABLE_}};
        m_err_      = {NUM_MASTERS{DISABLE_}};
        if (owned) begin
            bus_addr        = addr_arr[owner_q];
            bus_wr_data     = data_arr[owner_q];
            bus_rw          = m_rw[owner_q];
            bus_as_         = as_eff_;
            m_rdy_[owner_q] = bus_rdy_;
            if (err_q) m_err_[owner_q] = ENABLE_;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
            m_gnt_  <= {NUM_MASTERS{DISABLE_}};
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            m_gnt_  <= gnt_d;
            cnt_q   <= cnt_d;
            err_q   <= fire;
            abort_q <= abort_d;
        end
    end

    a_single_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(~m_gnt_));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int AW = BUS_ADDR_WIDTH;
    localparam int DW = BUS_DATA_WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req_, m_gnt_, m_as_, m_rw, m_rdy_, m_err_;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wr_data;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wr_data;
    logic            bus_as_, bus_rw, bus_rdy_;

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_      (m_req_),
        .m_gnt_      (m_gnt_),
        .m_addr      (m_addr),
        .m_as_       (m_as_),
        .m_rw        (m_rw),
        .m_wr_data   (m_wr_data),
        .m_rdy_      (m_rdy_),
        .m_err_      (m_err_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data),
        .bus_rdy_    (bus_rdy_)
    );

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [N-1:0]  rdy;
        logic [N-1:0]  err;
        logic          as_;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: owner (-1 = bus free), dead cycle after a release,
    // cycles the current strobe has waited, and whether an abort is masking the strobe.
    int own = -1, last = N - 1, waited = 0;
    bit dead = 0, aborted = 0, err_now = 0, model_live = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        m_addr[i*AW +: AW] = a;
    endtask

    // Predict this cycle's outputs, advance the model over the coming edge, then move to the next cycle.
    task automatic step();
        exp_t e;
        bit   strobe, found, fire;
        strobe = 0;
        if (own >= 0) strobe = !m_as_[own] && !aborted;
        if (model_live) begin
            e.gnt = '1; e.rdy = '1; e.err = '1;
            e.as_ = 1'b1; e.rw = READ; e.addr = '0; e.wd = '0;
            if (own >= 0) begin
                e.gnt[own] = 1'b0;
                e.rdy[own] = bus_rdy_;
                if (err_now) e.err[own] = 1'b0;
                e.as_  = !strobe;
                e.rw   = m_rw[own];
                e.addr = m_addr[own*AW +: AW];
                e.wd   = m_wr_data[own*DW +: DW];
            end
            exp_q.push_back(e);
        end
        if (rst) begin
            own = -1; last = N - 1; waited = 0;
            dead = 0; aborted = 0; err_now = 0; model_live = 1;
        end else if (own >= 0) begin
            fire = 0;
            if (strobe && bus_rdy_) begin
                waited++;
                if (waited == TO) begin
                    fire = 1; aborted = 1; waited = 0;
                end
            end else begin
                waited = 0;
            end
            if (m_as_[own]) aborted = 0;
            err_now = fire;
            if (m_req_[own] && !(strobe && bus_rdy_)) begin
                last = own; own = -1; dead = 1; err_now = 0;
            end
        end else if (dead) begin
            dead = 0;
        end else begin
            found = 0;
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (last + i) % N;
                if (!found && !m_req_[c]) begin
                    found = 1; own = c;
                end
            end
            waited = 0; aborted = 0; err_now = 0;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("m_gnt_",      32'(m_gnt_),      32'(e.gnt));
            chk("m_rdy_",      32'(m_rdy_),      32'(e.rdy));
            chk("m_err_",      32'(m_err_),      32'(e.err));
            chk("bus_as_",     32'(bus_as_),     32'(e.as_));
            chk("bus_rw",      32'(bus_rw),      32'(e.rw));
            chk("bus_addr",    32'(bus_addr),    32'(e.addr));
            chk("bus_wr_data", 32'(bus_wr_data), 32'(e.wd));
        end
    end

    initial begin
        rst = 1; m_req_ = '1; m_as_ = '1; m_rw = '1; bus_rdy_ = 1;
        m_addr = '0; m_wr_data = '0;
        #1;
        step(); step();
        rst = 0;

        // first grant to master 0, one write answered after a few cycles
        m_req_ = 4'b1110; set_addr(0, 16'h1234); m_wr_data[0 +: DW] = 16'hbeef;
        step(); step();
        m_as_[0] = 0; m_rw[0] = WRITE;
        step(); step();
        bus_rdy_ = 0; step();
        bus_rdy_ = 1; m_as_[0] = 1; step();

        // 0 releases with 1 and 3 waiting, then 1 -> 3 -> wrap to 0
        m_req_ = 4'b0101; repeat (4) step();
        m_req_ = 4'b0111; repeat (4) step();
        m_req_ = 4'b1110; repeat (4) step();

        // owner 2 strobes 0x0200 and the slave never answers
        m_req_ = 4'b1011; repeat (4) step();
        set_addr(2, 16'h0200); m_as_[2] = 0; m_rw[2] = READ;
        repeat (18) step();
        m_as_[2] = 1; repeat (2) step();

        // owner withdraws its request with an access pending
        m_as_[2] = 0; step(); step();
        m_req_ = 4'b1111; repeat (3) step();
        bus_rdy_ = 0; step();
        bus_rdy_ = 1; m_as_[2] = 1; repeat (3) step();

        // reset while master 1 owns, then reset with master 0 also requesting
        m_req_ = 4'b1101; set_addr(1, 16'h0abc); repeat (3) step();
        m_as_[1] = 0; repeat (2) step();
        rst = 1; step();
        rst = 0; repeat (3) step();
        m_req_ = 4'b1100; m_as_[1] = 1;
        rst = 1; step();
        rst = 0; repeat (3) step();

        // ready arrives exactly on the last cycle before abort
        m_as_[0] = 0; repeat (TO - 1) step();
        bus_rdy_ = 0; step();
        bus_rdy_ = 1; m_as_[0] = 1; repeat (2) step();
        m_req_ = 4'b1111; repeat (3) step();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) m_req_[i] = ~m_req_[i];
                if ($urandom_range(9) == 0) m_as_[i] = ~m_as_[i];
                m_rw[i] = 1'($urandom_range(1));
                m_addr[i*AW +: AW]    = AW'($urandom);
                m_wr_data[i*DW +: DW] = DW'($urandom);
            end
            bus_rdy_ = ($urandom_range(15) != 0);
            rst = ($urandom_range(299) == 0);
            step();
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
